// File: rtl/spart_bus_ctrl.sv
// SPART processor-side controller: bus decode, baud tick generator,
// receive byte/status holding and transmit buffer sequencing.
module spart_bus_ctrl #(
    parameter logic [15:0] DIV_RESET = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rda,
    output logic       tbr,
    output logic       baud_en,
    output logic       rx_en,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy
);

    typedef enum logic [1:0] {
        TX_EMPTY  = 2'd0,
        TX_PEND   = 2'd1,
        TX_LAUNCH = 2'd2,
        TX_GUARD  = 2'd3
    } tx_state_t;

    localparam int unsigned DIV_W = 16;

    tx_state_t         state, state_nxt;
    logic              load_tx;
    logic [7:0]        rx_buf;
    logic [7:0]        tx_buf;
    logic              ovr;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  cnt;

    logic bus_rd, bus_wr;
    logic rd_data, rd_status;
    logic wr_data, wr_ctrl, wr_div_lo, wr_div_hi;

    // Bus decode
    assign bus_rd    = iocs & iorw;
    assign bus_wr    = iocs & ~iorw;
    assign rd_data   = bus_rd & (ioaddr == 2'b00);
    assign rd_status = bus_rd & (ioaddr == 2'b01);
    assign wr_data   = bus_wr & (ioaddr == 2'b00);
    assign wr_ctrl   = bus_wr & (ioaddr == 2'b01);
    assign wr_div_lo = bus_wr & (ioaddr == 2'b10);
    assign wr_div_hi = bus_wr & (ioaddr == 2'b11);

    assign tx_data = tx_buf;

    // Read mux
    always_comb begin
        rdata = 8'h00;
        if (bus_rd) begin
            case (ioaddr)
                2'b00:   rdata = rx_buf;
                2'b01:   rdata = {5'b0, ovr, tbr, rda};
                2'b10:   rdata = div[7:0];
                default: rdata = div[15:8];
            endcase
        end
    end

    // Baud generator; a high-byte write restarts the count from the new divisor
    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= DIV_RESET;
            cnt     <= DIV_RESET;
            baud_en <= 1'b0;
        end else begin
            if (wr_div_lo) div[7:0]  <= wdata;
            if (wr_div_hi) div[15:8] <= wdata;
            if (wr_div_hi) begin
                cnt     <= {wdata, div[7:0]};
                baud_en <= 1'b0;
            end else if (cnt == 16'd0) begin
                cnt     <= div;
                baud_en <= 1'b1;
            end else begin
                cnt     <= cnt - 16'd1;
                baud_en <= 1'b0;
            end
        end
    end

    // Receive holding register and status; a new byte overrunning an unread one sets ovr
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_buf <= 8'h00;
            rda    <= 1'b0;
            ovr    <= 1'b0;
            rx_en  <= 1'b1;
        end else begin
            if (wr_ctrl) rx_en <= wdata[0];
            if (rx_done && rda && !rd_data) ovr <= 1'b1;
            else if (rd_status)             ovr <= 1'b0;
            if (rx_done) begin
                rx_buf <= rx_data;
                rda    <= 1'b1;
            end else if (rd_data) begin
                rda <= 1'b0;
            end
        end
    end

    // Transmit FSM state register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_EMPTY;
            tx_buf   <= 8'h00;
            tbr      <= 1'b1;
            tx_start <= 1'b0;
        end else begin
            state    <= state_nxt;
            tbr      <= (state_nxt == TX_EMPTY);
            tx_start <= (state_nxt == TX_LAUNCH);
            if (load_tx) tx_buf <= wdata;
        end
    end

    // Transmit FSM next state; GUARD gives the transmitter a cycle to raise tx_busy
    always_comb begin
        state_nxt = state;
        load_tx   = 1'b0;
        case (state)
            TX_EMPTY: begin
                if (wr_data) begin
                    load_tx   = 1'b1;
                    state_nxt = TX_PEND;
                end
            end
            TX_PEND:   if (!tx_busy) state_nxt = TX_LAUNCH;
            TX_LAUNCH: state_nxt = TX_GUARD;
            default:   state_nxt = TX_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Testbench for spart_bus_ctrl: directed vector table, corner-case sequences
// and random traffic checked against a cycle-level behavioural model.
module tb_spart_bus_ctrl;

    typedef struct packed {
        logic       rst;
        logic       cs;
        logic       rw;
        logic [1:0] a;
        logic [7:0] wd;
        logic       rxd;
        logic [7:0] rxdat;
        logic       busy;
    } bus_in_t;

    typedef struct packed {
        bus_in_t    in;
        logic [7:0] rdata;
        logic       rda;
        logic       tbr;
        logic       txs;
        logic [7:0] txd;
        logic       rxen;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, iocs, iorw, rx_done, tx_busy;
    logic [1:0] ioaddr;
    logic [7:0] wdata, rx_data;
    logic [7:0] rdata, tx_data;
    logic       rda, tbr, baud_en, rx_en, tx_start;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_rdata;

    // Reference model state
    logic [7:0]  m_rx_buf, m_txbuf;
    logic        m_rda, m_ovr, m_rx_en, m_baud;
    logic [15:0] m_div;
    int          m_stage;     // 0 empty, 1 pending, 2 launching, 3 guard
    int          m_elapsed, m_target;

    spart_bus_ctrl dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .wdata(wdata), .rdata(rdata), .rda(rda), .tbr(tbr), .baud_en(baud_en),
        .rx_en(rx_en), .rx_data(rx_data), .rx_done(rx_done), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input bus_in_t in);
        if (!(in.cs && in.rw)) return 8'h00;
        case (in.a)
            2'd0:    return m_rx_buf;
            2'd1:    return {5'b0, m_ovr, (m_stage == 0), m_rda};
            2'd2:    return m_div[7:0];
            default: return m_div[15:8];
        endcase
    endfunction

    task automatic m_update(input bus_in_t in);
        logic wr, rd0, rd1;
        if (in.rst) begin
            m_rx_buf = 8'h00; m_txbuf = 8'h00; m_rda = 1'b0; m_ovr = 1'b0;
            m_rx_en = 1'b1; m_baud = 1'b0; m_div = 16'd325; m_stage = 0;
            m_elapsed = 0; m_target = 325;
            return;
        end
        wr  = in.cs && !in.rw;
        rd0 = in.cs && in.rw && in.a == 2'd0;
        rd1 = in.cs && in.rw && in.a == 2'd1;
        // Tick when the cycles elapsed since the last (re)load reach the divisor latched then
        if (wr && in.a == 2'd3) begin
            m_target = int'({in.wd, m_div[7:0]}); m_elapsed = 0; m_baud = 1'b0;
        end else if (m_elapsed == m_target) begin
            m_target = int'(m_div); m_elapsed = 0; m_baud = 1'b1;
        end else begin
            m_elapsed++; m_baud = 1'b0;
        end
        if (wr && in.a == 2'd2) m_div[7:0]  = in.wd;
        if (wr && in.a == 2'd3) m_div[15:8] = in.wd;
        if (wr && in.a == 2'd1) m_rx_en = in.wd[0];
        if (in.rxd && m_rda && !rd0) m_ovr = 1'b1;
        else if (rd1)                m_ovr = 1'b0;
        if (in.rxd) begin m_rx_buf = in.rxdat; m_rda = 1'b1; end
        else if (rd0) m_rda = 1'b0;
        case (m_stage)
            0: if (wr && in.a == 2'd0) begin m_txbuf = in.wd; m_stage = 1; end
            1: if (!in.busy) m_stage = 2;
            2: m_stage = 3;
            default: m_stage = 0;
        endcase
    endtask

    // One clock: drive, check read data, clock, check registered outputs against model
    task automatic step(input bus_in_t in);
        @(negedge clk);
        rst = in.rst; iocs = in.cs; iorw = in.rw; ioaddr = in.a; wdata = in.wd;
        rx_done = in.rxd; rx_data = in.rxdat; tx_busy = in.busy;
        #1;
        last_rdata = rdata;
        chk("rdata", 16'(rdata), 16'(m_read(in)));
        @(posedge clk);
        m_update(in);
        #1;
        chk("rda", 16'(rda), 16'(m_rda));
        chk("tbr", 16'(tbr), 16'(m_stage == 0));
        chk("tx_start", 16'(tx_start), 16'(m_stage == 2));
        chk("tx_data", 16'(tx_data), 16'(m_txbuf));
        chk("baud_en", 16'(baud_en), 16'(m_baud));
        chk("rx_en", 16'(rx_en), 16'(m_rx_en));
    endtask

    function automatic bus_in_t bi(input logic cs, rw, input logic [1:0] a,
                                   input logic [7:0] wd, input logic rxd,
                                   input logic [7:0] rxdat, input logic busy);
        bus_in_t b;
        b.rst = 1'b0; b.cs = cs; b.rw = rw; b.a = a; b.wd = wd;
        b.rxd = rxd; b.rxdat = rxdat; b.busy = busy;
        return b;
    endfunction

    function automatic bus_in_t idle(input logic busy);
        return bi(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, busy);
    endfunction

    function automatic bus_in_t rd(input logic [1:0] a);
        return bi(1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00, 1'b0);
    endfunction

    function automatic bus_in_t wr(input logic [1:0] a, input logic [7:0] d, input logic busy);
        return bi(1'b1, 1'b0, a, d, 1'b0, 8'h00, busy);
    endfunction

    function automatic bus_in_t rx(input logic [7:0] d);
        return bi(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, d, 1'b0);
    endfunction

    function automatic vec_t v(input bus_in_t in, input logic [7:0] rdv, input logic rdav,
                               input logic tbrv, input logic txsv, input logic [7:0] txdv,
                               input logic rxenv);
        vec_t r;
        r.in = in; r.rdata = rdv; r.rda = rdav; r.tbr = tbrv; r.txs = txsv;
        r.txd = txdv; r.rxen = rxenv;
        return r;
    endfunction

    function automatic bus_in_t rst_in(input logic busy);
        bus_in_t b;
        b = idle(busy);
        b.rst = 1'b1;
        return b;
    endfunction

    vec_t vec[19];

    initial begin
        bus_in_t b;
        int n;
        int busy_q;

        // Directed vectors: inputs, rdata in that cycle, outputs after its edge
        vec[0]  = v(rd(2'd1),                                       8'h02, 0, 1, 0, 8'h00, 1);
        vec[1]  = v(rx(8'hA5),                                      8'h00, 1, 1, 0, 8'h00, 1);
        vec[2]  = v(rd(2'd1),                                       8'h03, 1, 1, 0, 8'h00, 1);
        vec[3]  = v(rd(2'd0),                                       8'hA5, 0, 1, 0, 8'h00, 1);
        vec[4]  = v(rx(8'h3C),                                      8'h00, 1, 1, 0, 8'h00, 1);
        vec[5]  = v(rx(8'h77),                                      8'h00, 1, 1, 0, 8'h00, 1);
        vec[6]  = v(rd(2'd1),                                       8'h07, 1, 1, 0, 8'h00, 1);
        vec[7]  = v(rd(2'd1),                                       8'h03, 1, 1, 0, 8'h00, 1);
        vec[8]  = v(bi(1, 1, 2'd0, 8'h00, 1, 8'h88, 0),             8'h77, 1, 1, 0, 8'h00, 1);
        vec[9]  = v(rd(2'd1),                                       8'h03, 1, 1, 0, 8'h00, 1);
        vec[10] = v(rd(2'd0),                                       8'h88, 0, 1, 0, 8'h00, 1);
        vec[11] = v(wr(2'd0, 8'h55, 1),                             8'h00, 0, 0, 0, 8'h55, 1);
        vec[12] = v(wr(2'd0, 8'h99, 1),                             8'h00, 0, 0, 0, 8'h55, 1);
        vec[13] = v(idle(1),                                        8'h00, 0, 0, 0, 8'h55, 1);
        vec[14] = v(idle(0),                                        8'h00, 0, 0, 1, 8'h55, 1);
        vec[15] = v(idle(0),                                        8'h00, 0, 0, 0, 8'h55, 1);
        vec[16] = v(idle(0),                                        8'h00, 0, 1, 0, 8'h55, 1);
        vec[17] = v(wr(2'd1, 8'hFE, 0),                             8'h00, 0, 1, 0, 8'h55, 0);
        vec[18] = v(wr(2'd1, 8'h01, 0),                             8'h00, 0, 1, 0, 8'h55, 1);

        m_update(rst_in(1'b0));
        step(rst_in(1'b0));
        step(rst_in(1'b0));
        chk("reset_rda", 16'(rda), 16'h0);
        chk("reset_tbr", 16'(tbr), 16'h1);
        chk("reset_baud_en", 16'(baud_en), 16'h0);
        chk("reset_rx_en", 16'(rx_en), 16'h1);
        chk("reset_tx_data", 16'(tx_data), 16'h00);
        chk("reset_tx_start", 16'(tx_start), 16'h0);
        chk("reset_rdata", 16'(rdata), 16'h00);

        // First tick DIV_RESET+1 cycles after reset, then every DIV_RESET+1
        for (int p = 0; p < 2; p++) begin
            n = 0;
            do begin step(idle(0)); n++; end while (!baud_en && n < 400);
            chk("baud_period", 16'(n), 16'd326);
        end

        for (int i = 0; i < 19; i++) begin
            step(vec[i].in);
            chk($sformatf("vec%0d_rdata", i), 16'(last_rdata), 16'(vec[i].rdata));
            chk($sformatf("vec%0d_rda", i), 16'(rda), 16'(vec[i].rda));
            chk($sformatf("vec%0d_tbr", i), 16'(tbr), 16'(vec[i].tbr));
            chk($sformatf("vec%0d_tx_start", i), 16'(tx_start), 16'(vec[i].txs));
            chk($sformatf("vec%0d_tx_data", i), 16'(tx_data), 16'(vec[i].txd));
            chk($sformatf("vec%0d_rx_en", i), 16'(rx_en), 16'(vec[i].rxen));
        end

        // Divisor 0 holds the tick high; a low-byte write to 3 lands at the next reload
        step(wr(2'd2, 8'h00, 0));
        step(wr(2'd3, 8'h00, 0));
        chk("div_hi_restart_baud", 16'(baud_en), 16'h0);
        for (int i = 0; i < 4; i++) begin
            step(idle(0));
            chk("div0_stuck_high", 16'(baud_en), 16'h1);
        end
        step(wr(2'd2, 8'h03, 0));
        chk("div3_first_reload", 16'(baud_en), 16'h1);
        for (int i = 0; i < 9; i++) begin
            step(idle(0));
            chk("div3_period4", 16'(baud_en), 16'((i % 4) == 0));
        end
        step(rd(2'd2));
        chk("read_div_lo", 16'(last_rdata), 16'h03);
        step(rd(2'd3));
        chk("read_div_hi", 16'(last_rdata), 16'h00);

        // Reset while a byte is pending: no launch, status and divisor restored
        step(wr(2'd0, 8'h12, 1));
        chk("pend_tbr", 16'(tbr), 16'h0);
        b = rx(8'h44); b.busy = 1'b1;
        step(b);
        chk("pend_rda", 16'(rda), 16'h1);
        step(rst_in(1'b1));
        chk("rst_tbr", 16'(tbr), 16'h1);
        chk("rst_rda", 16'(rda), 16'h0);
        for (int i = 0; i < 4; i++) begin
            step(idle(0));
            chk("rst_no_tx_start", 16'(tx_start), 16'h0);
        end
        step(rd(2'd1));
        chk("rst_status", 16'(last_rdata), 16'h02);
        step(rd(2'd3));
        chk("rst_div_hi", 16'(last_rdata), 16'h01);
        step(rd(2'd2));
        chk("rst_div_lo", 16'(last_rdata), 16'h45);

        // Random traffic with small divisors so ticks are frequent
        busy_q = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) busy_q = 1 - busy_q;
            b.rst   = ($urandom_range(0, 499) == 0);
            b.cs    = $urandom_range(0, 1) == 1;
            b.rw    = $urandom_range(0, 1) == 1;
            b.a     = 2'($urandom_range(0, 3));
            b.wd    = 8'($urandom);
            if (b.a == 2'd3 && $urandom_range(0, 9) != 0) b.wd = 8'h00;
            if (b.a == 2'd2 && $urandom_range(0, 3) != 0) b.wd = 8'($urandom_range(0, 12));
            b.rxd   = ($urandom_range(0, 7) == 0);
            b.rxdat = 8'($urandom);
            b.busy  = busy_q[0];
            step(b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
